// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter in front of a single-port word memory.
// Port A (instruction fetch) and port B (load/store) share the memory; each
// access walks IDLE -> ACCESS -> DONE, so one access completes every 3 cycles.
// B normally wins a tie, but after STARVE_MAX consecutive tie losses A is
// forced through so fetch cannot be locked out by a busy load/store stream.
module mem_access_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_DEPTH  = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // port A: instruction fetch
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    // port B: load/store unit
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH   = (ADDR_W + 1)'(MEM_DEPTH);

    logic [1:0]        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              owner_b;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic is_idle, is_access, is_done;
    logic a_win, b_win, in_range;

    assign is_idle   = (state == IDLE);
    assign is_access = (state == ACCESS);
    assign is_done   = (state == DONE);

    // A wins when alone or once it has lost STARVE_MAX ties in a row.
    assign a_win = a_req & (~b_req | (starve_cnt == CNT_MAX));
    assign b_win = b_req & ~a_win;

    // Grants are gated by rst_n so they drop immediately on an async reset
    // even while a requester keeps its req high.
    assign a_gnt = rst_n & is_idle & a_win;
    assign b_gnt = rst_n & is_idle & b_win;

    assign in_range = ({1'b0, addr_q} < DEPTH);

    // Memory strobes only exist in ACCESS; everything is parked at 0 otherwise.
    assign mem_addr  = is_access ? addr_q  : '0;
    assign mem_wdata = is_access ? wdata_q : '0;
    assign mem_we    = is_access & in_range &  we_q;
    assign mem_re    = is_access & in_range & ~we_q;

    // Completion goes only to the owner; rdata_q is already 0 for writes/errors.
    assign a_done  = is_done & ~owner_b;
    assign b_done  = is_done &  owner_b;
    assign a_rdata = a_done ? rdata_q : '0;
    assign b_rdata = b_done ? rdata_q : '0;
    assign a_err   = a_done & ~in_range;
    assign b_err   = b_done & ~in_range;

    // Access sequencer: latch the winner in IDLE, strobe memory, report result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner_b    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_win || b_win) begin
                        state   <= ACCESS;
                        owner_b <= b_win;
                        we_q    <= b_win ? b_we    : a_we;
                        addr_q  <= b_win ? b_addr  : a_addr;
                        wdata_q <= b_win ? b_wdata : a_wdata;
                        // b_win with a_req implies the count is below max.
                        if (a_win)
                            starve_cnt <= '0;
                        else if (a_req)
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                ACCESS: begin
                    rdata_q <= (in_range && !we_q) ? mem_rdata : '0;
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed table of single accesses, starvation,
// async-reset and out-of-range sequences, then random traffic. A transaction-
// level model (free-at cycle, tie-loss counter, reference memory) checks every
// output on every falling edge.
module tb_mem_access_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_DEPTH  = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_req, a_we, a_gnt, a_done, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;
    logic              b_req, b_we, b_gnt, b_done, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata, b_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we, mem_re;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 5) ? 32'hDEADBEEF : (32'hA5000000 + DATA_W'(i * 32'h00010101));
    endfunction

    // Memory the DUT talks to: combinational read, write on rising edge.
    logic [DATA_W-1:0] tbmem [MEM_DEPTH];
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) tbmem[i] <= init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we && mem_addr < MEM_DEPTH) tbmem[mem_addr[4:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr < MEM_DEPTH) ? tbmem[mem_addr[4:0]] : '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DATA_W-1:0] ref_mem [MEM_DEPTH];
    int   cyc, next_free, acc_cyc, done_cyc, a_loss;
    logic t_b, t_we, t_inr;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata, t_rdata;
    logic a_owed, b_owed;
    logic ea_gnt, eb_gnt, e_acc, ea_done, eb_done;

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);
        cyc = 0; next_free = 0; acc_cyc = -1; done_cyc = -1; a_loss = 0;
        a_owed = 0; b_owed = 0;
        t_b = 0; t_we = 0; t_inr = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ctrl", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_we, mem_re}, 0);
                check("rst_a_rdata", a_rdata, 0);
                check("rst_b_rdata", b_rdata, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
                next_free = 0; acc_cyc = -1; done_cyc = -1; a_loss = 0;
                a_owed = 0; b_owed = 0;
            end else begin
                ea_gnt = 0; eb_gnt = 0;
                if (cyc >= next_free) begin
                    if (a_req && (!b_req || a_loss >= STARVE_MAX)) ea_gnt = 1;
                    else if (b_req) eb_gnt = 1;
                end
                e_acc   = (cyc == acc_cyc);
                ea_done = (cyc == done_cyc) && !t_b;
                eb_done = (cyc == done_cyc) &&  t_b;
                check("gnt", {a_gnt, b_gnt}, {ea_gnt, eb_gnt});
                check("mem_strobe", {mem_we, mem_re}, {e_acc & t_inr & t_we, e_acc & t_inr & ~t_we});
                check("mem_we_re_excl", mem_we & mem_re, 0);
                check("mem_addr", mem_addr, e_acc ? t_addr : '0);
                check("mem_wdata", mem_wdata, e_acc ? t_wdata : '0);
                check("a_done_err", {a_done, a_err}, {ea_done, ea_done & ~t_inr});
                check("a_rdata", a_rdata, ea_done ? t_rdata : '0);
                check("b_done_err", {b_done, b_err}, {eb_done, eb_done & ~t_inr});
                check("b_rdata", b_rdata, eb_done ? t_rdata : '0);
                if (a_done) check("a_done_after_gnt", a_owed, 1);
                if (b_done) check("b_done_after_gnt", b_owed, 1);
                if (a_gnt) a_owed = 1; else if (a_done) a_owed = 0;
                if (b_gnt) b_owed = 1; else if (b_done) b_owed = 0;
                if (ea_gnt || eb_gnt) begin
                    if (ea_gnt) a_loss = 0;
                    else if (a_req) a_loss++;
                    t_b     = eb_gnt;
                    t_we    = eb_gnt ? b_we    : a_we;
                    t_addr  = eb_gnt ? b_addr  : a_addr;
                    t_wdata = eb_gnt ? b_wdata : a_wdata;
                    t_inr   = (t_addr < MEM_DEPTH);
                    t_rdata = (t_inr && !t_we) ? ref_mem[t_addr[4:0]] : '0;
                    if (t_inr && t_we) ref_mem[t_addr[4:0]] = t_wdata;
                    acc_cyc = cyc + 1; done_cyc = cyc + 2; next_free = cyc + 3;
                end
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic              port_b;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
        logic              exp_mem_we;
        logic              exp_mem_re;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [ADDR_W-1:0] rand_addr();
        int unsigned r = $urandom_range(0, 7);
        if (r < 6)  return ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
        if (r == 6) return ADDR_W'($urandom_range(MEM_DEPTH, MEM_DEPTH + 7));
        return 32'h80000000 | ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; a_req = 0; b_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // One access from an idle arbiter, checked at n, n+1 and n+2.
    task automatic do_txn(input vec_t v, output time t_gnt);
        @(posedge clk); #1;
        if (v.port_b) begin b_req = 1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; end
        else          begin a_req = 1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; end
        @(negedge clk);
        check("tbl_gnt", {a_gnt, b_gnt}, {~v.port_b, v.port_b});
        t_gnt = $time;
        @(posedge clk); #1;
        a_req = 0; b_req = 0; a_wdata = $urandom; b_wdata = $urandom;
        @(negedge clk);
        check("tbl_mem_strobe", {mem_we, mem_re}, {v.exp_mem_we, v.exp_mem_re});
        if (v.exp_mem_we || v.exp_mem_re) check("tbl_mem_addr", mem_addr, v.addr);
        if (v.exp_mem_we) check("tbl_mem_wdata", mem_wdata, v.wdata);
        @(negedge clk);
        check("tbl_done", {a_done, b_done}, {~v.port_b, v.port_b});
        check("tbl_err", v.port_b ? b_err : a_err, v.exp_err);
        check("tbl_rdata", v.port_b ? b_rdata : a_rdata, v.exp_rdata);
    endtask

    initial begin
        time  t_prev, t_now;
        int   grants;
        logic a_got, b_got;

        vecs[0] = '{1'b0, 1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'd3,          32'h12345678, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd3,          32'h0,        32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'd32,         32'h0,        32'h0,        1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'd31,         32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'd31,         32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h80000003,   32'h55555555, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'd3,          32'h0,        32'h12345678, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'd40,         32'h77777777, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'd0,          32'h0,        32'hA5000000, 1'b0, 1'b0, 1'b1};

        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Directed single accesses.
        t_prev = 0;
        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i], t_now);
            if (i == 2) check("b_gnt_spacing", 64'(t_now - t_prev), 64'd30);
            t_prev = t_now;
        end

        // Both ports requesting continuously: B,B,B,B,A repeating, 3-cycle spacing.
        do_reset();
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 32'd1;
        b_req = 1; b_we = 0; b_addr = 32'd2;
        grants = 0; t_prev = 0;
        for (int c = 0; c < 60 && grants < 10; c++) begin
            @(negedge clk);
            if (a_gnt || b_gnt) begin
                check("starve_order", {a_gnt, b_gnt}, (grants % 5 == 4) ? 2'b10 : 2'b01);
                if (grants > 0) check("starve_spacing", 64'($time - t_prev), 64'd30);
                t_prev = $time;
                grants++;
            end
        end
        check("starve_grant_count", grants, 10);
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        repeat (4) @(posedge clk);

        // Async reset during a B read's ACCESS cycle.
        #1;
        b_req = 1; b_we = 0; b_addr = 32'd7;
        @(negedge clk);
        check("rst_seq_b_gnt", b_gnt, 1);
        @(posedge clk); #1;
        b_req = 0;
        check("rst_seq_access_re", mem_re, 1);
        rst_n = 0;
        #1;
        check("rst_async_ctrl", {a_gnt, a_done, a_err, b_gnt, b_done, b_err, mem_we, mem_re}, 0);
        check("rst_async_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1;
        a_req = 1; a_we = 0; a_addr = 32'd2;
        @(negedge clk);
        check("post_rst_a_gnt", a_gnt, 1);
        @(posedge clk); #1;
        a_req = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("no_b_done_after_rst", b_done, 0);
        end

        // Random traffic against the model; requesters hold until granted.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a_got = a_gnt; b_got = b_gnt;
            @(posedge clk); #1;
            if (!a_req || a_got) begin
                a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
                a_addr = rand_addr(); a_wdata = $urandom;
            end
            if (!b_req || b_got) begin
                b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
                b_addr = rand_addr(); b_wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
